// File: rtl/jpeg_dec_pkg.sv
// jpeg_dec_pkg: marker byte constants and reader FSM state type shared by the JPEG decoder blocks
package jpeg_dec_pkg;
  localparam logic [7:0] M_RST0     = 8'hD0;
  localparam logic [7:0] M_RST7     = 8'hD7;
  localparam logic [7:0] M_EOI      = 8'hD9;
  localparam logic [7:0] BYTE_STUFF = 8'h00;
  localparam logic [7:0] BYTE_FF    = 8'hFF;
  typedef enum logic [1:0] {S_DATA, S_FF, S_MARKER} rdr_state_t;
endpackage

// File: rtl/jpeg_bit_shift_buffer.sv
// jpeg_bit_shift_buffer: left-aligned bit window with append-8 and consume-N ports; clk, rst (async), clear, push/push_byte, consume/consume_len -> peek (top bits), count, underrun
module jpeg_bit_shift_buffer #(
  parameter int WIN_W  = 32,
  parameter int PEEK_W = 16,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [7:0]        push_byte,
  input  logic              consume,
  input  logic [4:0]        consume_len,
  output logic [PEEK_W-1:0] peek,
  output logic [CNT_W-1:0]  count,
  output logic              underrun
);
  logic [WIN_W-1:0] win, rem_win, nxt_win;
  logic [CNT_W-1:0] len, rem_cnt, nxt_cnt;
  logic             ok;
  // Bits below count are kept zero so an append is a plain OR at the tail.
  always_comb begin
    len      = CNT_W'(consume_len);
    ok       = consume && consume_len != 5'd0 && len <= CNT_W'(PEEK_W);
    underrun = ok && len > count;
    rem_cnt  = !ok ? count : underrun ? '0 : count - len;
    rem_win  = !ok ? win : underrun ? '0 : win << len;
    nxt_win  = push ? rem_win | ({push_byte, {(WIN_W-8){1'b0}}} >> rem_cnt) : rem_win;
    nxt_cnt  = push ? rem_cnt + CNT_W'(8) : rem_cnt;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      win   <= '0;
      count <= '0;
    end else begin
      win   <= clear ? '0 : nxt_win;
      count <= clear ? '0 : nxt_cnt;
    end
  assign peek = win[WIN_W-1 -: PEEK_W];
endmodule

// File: rtl/jpeg_entropy_bit_reader.sv
// jpeg_entropy_bit_reader: strips 0xFF00 stuffing / 0xFF fill, detects markers and serves an MSB-first peek window; byte in (in_valid/in_data/in_ready), peek out (peek_valid/peek_data/bits_avail), consume/consume_len, marker_valid/marker_code/marker_ack, err_underrun
module jpeg_entropy_bit_reader
  import jpeg_dec_pkg::*;
#(
  parameter int WIN_W  = 32,
  parameter int PEEK_W = 16,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              peek_valid,
  output logic [PEEK_W-1:0] peek_data,
  output logic [CNT_W-1:0]  bits_avail,
  input  logic              consume,
  input  logic [4:0]        consume_len,
  output logic              marker_valid,
  output logic [7:0]        marker_code,
  input  logic              marker_ack,
  output logic              err_underrun
);
  rdr_state_t        state, state_nxt;
  logic              rdy_en, accept, ack, push, underrun;
  logic [7:0]        push_byte;
  logic [PEEK_W-1:0] peek;
  jpeg_bit_shift_buffer #(.WIN_W(WIN_W), .PEEK_W(PEEK_W), .CNT_W(CNT_W)) u_buf (
    .clk(clk), .rst(rst), .clear(ack), .push(push), .push_byte(push_byte),
    .consume(consume && !ack), .consume_len(consume_len),
    .peek(peek), .count(bits_avail), .underrun(underrun)
  );
  // rdy_en holds in_ready low for the first cycle after reset release.
  assign in_ready     = rdy_en && state != S_MARKER && bits_avail <= CNT_W'(WIN_W-8);
  assign accept       = in_valid && in_ready;
  assign ack          = state == S_MARKER && marker_ack;
  assign marker_valid = state == S_MARKER;
  assign peek_valid   = bits_avail >= CNT_W'(PEEK_W) || (marker_valid && bits_avail != '0);
  // Once a marker ends the segment, missing tail bits read as 1s.
  assign peek_data    = peek | (marker_valid ? {PEEK_W{1'b1}} >> bits_avail : '0);
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_byte = in_data;
    case (state)
      S_DATA: if (accept) begin
        if (in_data == BYTE_FF) state_nxt = S_FF;
        else push = 1'b1;
      end
      S_FF: if (accept) begin
        if (in_data == BYTE_STUFF) begin
          push      = 1'b1;
          push_byte = BYTE_FF;
          state_nxt = S_DATA;
        end else if (in_data != BYTE_FF) state_nxt = S_MARKER;
      end
      S_MARKER: if (marker_ack) state_nxt = S_DATA;
      default: state_nxt = S_DATA;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= S_DATA;
      rdy_en       <= 1'b0;
      marker_code  <= '0;
      err_underrun <= 1'b0;
    end else begin
      state        <= state_nxt;
      rdy_en       <= 1'b1;
      marker_code  <= (state == S_FF && state_nxt == S_MARKER) ? in_data : marker_code;
      err_underrun <= err_underrun | underrun;
    end
endmodule
